line_mem_model: RTL
===================

// Module: line_mem_model
// PURPOSE
// Line-granular main-memory model on the downstream side of the cache miss/write-back port.
// Services one 256-bit line request at a time: reads return stored data; writes update it.
// Fixed, parameterised latency. Replaces the fixed-pattern memory stub in synthesis and simulation tops.
// Lines never written read back as {8{addr[14:0],17'd0}}, matching the existing stub's data pattern.
// PARAMETERS
// IDX_W     6   line-index bits kept in storage; DEPTH = 2**IDX_W lines; addr[IDX_W-1:0] indexes, upper bits alias
// RD_LAT    20  edges from read acceptance to response pulse; must be >= 1
// WR_LAT    20  edges from write acceptance to response pulse; must be >= 1
// PORTS
// clk             in   1    clock, rising edge
// rst_n           in   1    asynchronous active-low reset
// mem_req_valid   in   1    request level; cache holds it high until it sees mem_resp_valid
// mem_req_rw      in   1    1 = write line, 0 = read line
// mem_req_addr    in   15   line address
// mem_req_wdata   in   256  write line data
// mem_resp_valid  out  1    one-cycle pulse: read data valid / write complete
// mem_resp_rdata  out  256  read line data; holds its value between responses
// mem_busy        out  1    high in every state except IDLE
// rd_count        out  16   accepted reads, saturating at 16'hFFFF
// wr_count        out  16   accepted writes, saturating at 16'hFFFF
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE; mem_resp_valid=0; mem_resp_rdata=0; counters=0; all line-written bits=0.
// - Storage: DEPTH x 256 data array, unreset, plus DEPTH written-bits, reset to 0.
// - FSM: IDLE -> WAIT -> RESP -> GAP -> IDLE.
//   IDLE: on an edge with mem_req_valid=1, latch rw/addr/wdata, load delay counter = LAT-1 (RD_LAT or WR_LAT), bump rd/wr_count, go WAIT.
//   WAIT: decrement counter each edge; at 0 go RESP.
//   RESP: mem_resp_valid=1 for exactly this cycle.
//     Read: rdata = written[idx] ? array[idx] : {8{addr,17'd0}}, where addr is the latched 15-bit address.
//     Write: array[idx] <= latched wdata; written[idx] <= 1, committed on the edge leaving RESP.
//   GAP: one dead cycle. mem_req_valid is ignored here because the cache's request is stale.
- Latency: response pulse is high in the cycle beginning LAT edges after the accepting edge.
//   Idle-to-idle occupancy per request is LAT+2 cycles.
// - Only one request is outstanding. Changes to req inputs after acceptance are ignored; the latched copy is used.
// - Read after write to the same idx, issued as a later request, returns the written data.
//   An aliased address (same idx, different upper bits) also returns the stored data; aliasing is intended.
// - Counters saturate; they do not wrap.
// - Reset mid-operation: an in-flight request is dropped and no pulse is issued. A pending write is not committed.
//   All lines read as the pattern again afterwards.
// - mem_resp_valid is never high in two consecutive cycles.
// TESTING
// T1 read 15'h0005 unwritten, RD_LAT=20 -> pulse 20 edges after acceptance, rdata={8{15'h0005,17'd0}}, rd_count=1
// T2 write 15'h0003 data=256'hA5..A5, then read 15'h0003 -> write pulse after 20 edges; read returns A5..A5; wr_count=1, rd_count=1
// T3 hold valid high through the pulse -> GAP cycle ignores it; next acceptance occurs >=2 cycles after the pulse; exactly one pulse per request
// T4 write 15'h0043 (IDX_W=6, aliases 15'h0003), then read 15'h0003 -> returns the 15'h0043 write data
// T5 assert rst_n low at WAIT count 10 of a write to 15'h0007 -> no pulse; then read 15'h0007 returns pattern; counters=0 until the new read
// T6 force rd_count=16'hFFFE, issue 3 reads -> rd_count stays 16'hFFFF

Source files
------------

// File: rtl/line_mem_model.sv
// Line-granular main-memory model for the cache miss/write-back port.
// One 256-bit request in flight at a time, fixed per-direction latency.
`timescale 1ns/1ps
module line_mem_model #(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned RD_LAT = 20,
  parameter int unsigned WR_LAT = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_req_valid,
  input  logic         mem_req_rw,
  input  logic [14:0]  mem_req_addr,
  input  logic [255:0] mem_req_wdata,
  output logic         mem_resp_valid,
  output logic [255:0] mem_resp_rdata,
  output logic         mem_busy,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
);

  localparam int unsigned DEPTH   = 1 << IDX_W;
  localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned DLY_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;

  state_t             state, state_nxt;
  logic               req_rw;
  logic [14:0]        req_addr;
  logic [255:0]       req_wdata;
  logic [DLY_W-1:0]   dly;
  logic [DEPTH-1:0]   written;
  logic [255:0]       mem_array [DEPTH];
  logic [IDX_W-1:0]   idx;
  logic               accept;
  logic               wait_done;
  logic               commit_wr;

  assign idx       = req_addr[IDX_W-1:0];
  assign accept    = (state == IDLE) && mem_req_valid;
  assign wait_done = (state == WAIT) && (dly == '0);
  assign commit_wr = (state == RESP) && req_rw;
  assign mem_busy  = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_req_valid) state_nxt = WAIT;
      WAIT:    if (dly == '0)     state_nxt = RESP;
      RESP:    state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_rw         <= 1'b0;
      req_addr       <= '0;
      req_wdata      <= '0;
      dly            <= '0;
      rd_count       <= '0;
      wr_count       <= '0;
      mem_resp_valid <= 1'b0;
      mem_resp_rdata <= '0;
      written        <= '0;
    end else begin
      state          <= state_nxt;
      mem_resp_valid <= wait_done;
      if (accept) begin
        req_rw    <= mem_req_rw;
        req_addr  <= mem_req_addr;
        req_wdata <= mem_req_wdata;
        if (mem_req_rw) begin
          dly <= DLY_W'(WR_LAT - 1);
          if (wr_count != '1) wr_count <= wr_count + 16'd1;
        end else begin
          dly <= DLY_W'(RD_LAT - 1);
          if (rd_count != '1) rd_count <= rd_count + 16'd1;
        end
      end else if ((state == WAIT) && (dly != '0)) begin
        dly <= dly - 1'b1;
      end
      // Read data is captured on the edge entering RESP so it is valid with the pulse
      if (wait_done && !req_rw)
        mem_resp_rdata <= written[idx] ? mem_array[idx] : {8{req_addr, 17'd0}};
      if (commit_wr)
        written[idx] <= 1'b1;
    end
  end

  // Unreset storage; async reset forces IDLE so a pending write can never commit
  always_ff @(posedge clk) begin
    if (commit_wr)
      mem_array[idx] <= req_wdata;
  end

endmodule
